// File: rtl/truth_table_sweeper_if.sv
// Row-capture bus between truth_table_sweeper and the logic under test / row consumer.
// master = sweeper side, slave = environment side (stimulus source, consumer).
interface truth_table_sweeper_if #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 10
);
    logic             start;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] resp;
    logic             row_valid;
    logic             row_ready;
    logic [IN_W-1:0]  row_idx;
    logic [OUT_W-1:0] row_out;
    logic             row_mark;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] sig;

    modport master (
        input  start, resp, row_ready,
        output stim, row_valid, row_idx, row_out, row_mark, busy, done, sig
    );

    modport slave (
        output start, resp, row_ready,
        input  stim, row_valid, row_idx, row_out, row_mark, busy, done, sig
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Clocked truth-table sweeper: walks every stimulus value, settles, captures and presents each row.
// Optional running signature enabled by defining SWEEPER_SIGNATURE_EN.
module truth_table_sweeper #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned SETTLE = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    truth_table_sweeper_if.master    bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    if (IN_W < 2 || IN_W > 16) begin : g_bad_in_w
        $error("truth_table_sweeper: IN_W out of range 2..16");
    end
    if (OUT_W < 1 || OUT_W > 32) begin : g_bad_out_w
        $error("truth_table_sweeper: OUT_W out of range 1..32");
    end
    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("truth_table_sweeper: SETTLE out of range 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [IN_W-1:0]  row_idx_q, row_idx_d;
    logic [OUT_W-1:0] row_out_q, row_out_d;
    logic             row_valid_q, row_valid_d;
    logic             row_mark_q, row_mark_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SWEEPER_SIGNATURE_EN
    logic [OUT_W-1:0] sig_q, sig_d;
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stim_q      <= '0;
            row_idx_q   <= '0;
            row_out_q   <= '0;
            row_valid_q <= 1'b0;
            row_mark_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SWEEPER_SIGNATURE_EN
            sig_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stim_q      <= stim_d;
            row_idx_q   <= row_idx_d;
            row_out_q   <= row_out_d;
            row_valid_q <= row_valid_d;
            row_mark_q  <= row_mark_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SWEEPER_SIGNATURE_EN
            sig_q       <= sig_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stim_d      = stim_q;
        row_idx_d   = row_idx_q;
        row_out_d   = row_out_q;
        row_valid_d = row_valid_q;
        row_mark_d  = row_mark_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef SWEEPER_SIGNATURE_EN
        sig_d       = sig_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETTLE;
                    stim_d  = '0;
                    busy_d  = 1'b1;
                    cnt_d   = RELOAD;
`ifdef SWEEPER_SIGNATURE_EN
                    sig_d   = '0;
`endif
                end
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d     = ST_PRESENT;
                    row_out_d   = bus.resp;
                    row_idx_d   = stim_q;
                    row_valid_d = 1'b1;
                    row_mark_d  = (stim_q[1:0] == 2'b11);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_PRESENT: begin
                if (bus.row_ready) begin
                    row_valid_d = 1'b0;
                    row_mark_d  = 1'b0;
`ifdef SWEEPER_SIGNATURE_EN
                    sig_d = ((sig_q << 1) | (sig_q >> (OUT_W - 1))) ^ row_out_q;
`endif
                    // Terminal row is detected by value so the index never wraps
                    if (row_idx_q == {IN_W{1'b1}}) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        stim_d  = '0;
                    end else begin
                        state_d = ST_SETTLE;
                        stim_d  = stim_q + IN_W'(1);
                        cnt_d   = RELOAD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.stim      = stim_q;
    assign bus.row_idx   = row_idx_q;
    assign bus.row_out   = row_out_q;
    assign bus.row_valid = row_valid_q;
    assign bus.row_mark  = row_mark_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef SWEEPER_SIGNATURE_EN
    assign bus.sig       = sig_q;
`else
    assign bus.sig       = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised self-checking bench for truth_table_sweeper against a row-level reference model.
module tb_truth_table_sweeper;
    localparam int unsigned IN_W   = 4;
    localparam int unsigned OUT_W  = 10;
    localparam int unsigned SETTLE = 5;
    localparam int unsigned ROWS   = 1 << IN_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    truth_table_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Logic under test: resp = (stim * mul) ^ key, with an optional glitch mask
    logic [OUT_W-1:0] mul, key, glitch;
    assign bus.resp = OUT_W'(32'(bus.stim) * 32'(mul)) ^ key ^ glitch;

    int n_checks = 0;
    int n_fail   = 0;
    logic [OUT_W-1:0] sig_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUT_W-1:0] model_resp(input int x);
        return OUT_W'(32'(x) * 32'(mul)) ^ key;
    endfunction

    function automatic logic [OUT_W-1:0] exp_sig();
`ifdef SWEEPER_SIGNATURE_EN
        return sig_m;
`else
        return '0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_stim"},  32'(bus.stim),      32'd0);
        check({tag, "_idx"},   32'(bus.row_idx),   32'd0);
        check({tag, "_out"},   32'(bus.row_out),   32'd0);
        check({tag, "_sig"},   32'(bus.sig),       32'd0);
        check({tag, "_valid"}, 32'(bus.row_valid), 32'd0);
        check({tag, "_mark"},  32'(bus.row_mark),  32'd0);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
        check({tag, "_done"},  32'(bus.done),      32'd0);
    endtask

    // One sweep from the start edge; returns at the done edge (or after an abort)
    task automatic sweep(input int stall_row, input int stall_len, input bit rnd_stall,
                         input int glitch_row, input int abort_row, input bit hold_start);
        int cyc;
        int n;
        int stalls;
        stalls = 0;
        bus.start = 1'b1;
        tick();
        cyc = 0;
        sig_m = '0;
        check("e0_busy",  32'(bus.busy),      32'd1);
        check("e0_stim",  32'(bus.stim),      32'd0);
        check("e0_valid", 32'(bus.row_valid), 32'd0);
        check("e0_sig",   32'(bus.sig),       32'(exp_sig()));
        if (!hold_start) bus.start = 1'b0;

        for (int r = 0; r < int'(ROWS); r++) begin
            for (int k = 1; k <= int'(SETTLE); k++) begin
                if (r == abort_row && k == 2) begin
                    rst = 1'b1;
                    #1;
                    check_all_zero("abort");
                    tick();
                    rst = 1'b0;
                    tick();
                    check_all_zero("post_abort");
                    return;
                end
                tick();
                cyc++;
                check("settle_stim",  32'(bus.stim),      32'(r));
                check("settle_valid", 32'(bus.row_valid), (k == int'(SETTLE)) ? 32'd1 : 32'd0);
            end
            check("row_idx",  32'(bus.row_idx),  32'(r));
            check("row_out",  32'(bus.row_out),  32'(model_resp(r)));
            check("row_mark", 32'(bus.row_mark), ((r % 4) == 3) ? 32'd1 : 32'd0);
            check("row_busy", 32'(bus.busy),     32'd1);

            n = (r == stall_row) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            if (r == glitch_row && n < 3) n = 3;
            for (int s = 0; s < n; s++) begin
                if (r == glitch_row) glitch = OUT_W'($urandom_range(1, (1 << OUT_W) - 1));
                tick();
                cyc++;
                stalls++;
                check("hold_valid", 32'(bus.row_valid), 32'd1);
                check("hold_idx",   32'(bus.row_idx),   32'(r));
                check("hold_out",   32'(bus.row_out),   32'(model_resp(r)));
                check("hold_stim",  32'(bus.stim),      32'(r));
            end

            bus.row_ready = 1'b1;
            tick();
            cyc++;
            bus.row_ready = 1'b0;
            glitch = '0;
            sig_m = ({sig_m[OUT_W-2:0], sig_m[OUT_W-1]}) ^ model_resp(r);
            check("acc_valid", 32'(bus.row_valid), 32'd0);
            check("acc_mark",  32'(bus.row_mark),  32'd0);
            check("acc_sig",   32'(bus.sig),       32'(exp_sig()));
            if (r == int'(ROWS) - 1) begin
                check("done_pulse", 32'(bus.done), 32'd1);
                check("done_busy",  32'(bus.busy), 32'd0);
                check("done_stim",  32'(bus.stim), 32'd0);
            end else begin
                check("acc_done", 32'(bus.done), 32'd0);
                check("acc_stim", 32'(bus.stim), 32'(r + 1));
            end
        end
        check("sweep_cycles", 32'(cyc), 32'(int'(ROWS) * (int'(SETTLE) + 1) + stalls));
    endtask

    task automatic idle_after_done();
        tick();
        check("idle_done", 32'(bus.done),      32'd0);
        check("idle_busy", 32'(bus.busy),      32'd0);
        check("idle_valid",32'(bus.row_valid), 32'd0);
        check("idle_sig",  32'(bus.sig),       32'(exp_sig()));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.row_ready = 1'b0;
        glitch = '0;
        mul = OUT_W'(1);
        key = '0;
        sig_m = '0;
        #12;
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();
        check_all_zero("idle");

        // Identity response, no stalls: 96-cycle sweep
        sweep(-1, 0, 1'b0, -1, -1, 1'b0);
        idle_after_done();

        // Backpressure on row 5, glitch on row 2
        mul = OUT_W'($urandom_range(1, 1023));
        key = OUT_W'($urandom);
        sweep(5, 7, 1'b0, 2, -1, 1'b0);
        idle_after_done();

        // Abort during settle of row 9, then restart from row 0
        sweep(-1, 0, 1'b1, -1, 9, 1'b0);
        sweep(-1, 0, 1'b1, -1, -1, 1'b0);
        idle_after_done();

        // Start held high: second sweep begins the cycle after done
        mul = OUT_W'($urandom_range(1, 1023));
        key = OUT_W'($urandom);
        sweep(-1, 0, 1'b1, -1, -1, 1'b1);
        sweep(-1, 0, 1'b1, 7, -1, 1'b1);
        bus.start = 1'b0;
        idle_after_done();

        // Random sweeps
        for (int t = 0; t < 3; t++) begin
            mul = OUT_W'($urandom);
            key = OUT_W'($urandom);
            sweep(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(1, 9)), 1'b1,
                  int'($urandom_range(0, ROWS - 1)), -1, 1'b0);
            idle_after_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
